// File: rtl/ysyx_210544_ifu_fq_pkg.sv
// Shared types and constants for the prefetching fetch unit and its queue.
// State encoding of the bus-request FSM plus the default reset fetch address.
package ysyx_210544_ifu_fq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_KILL = 2'b10
    } ifu_state_e;

    localparam logic [63:0] PC_START_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_210544_ifu_fq_fifo.sv
// Generic synchronous FIFO holding fetched {pc, inst} entries.
// Head data is read combinationally from the storage array; flush wins over push/pop.
module ysyx_210544_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ysyx_210544_ifu_fq.sv
// Prefetching fetch unit: single-request bus FSM feeding a fetch queue toward decode.
// Define YSYX_210544_IFU_BYPASS_EN to forward bus data straight to decode when the queue is empty.
module ysyx_210544_ifu_fq
    import ysyx_210544_ifu_fq_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(PC_START_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bus_ack,
    input  logic [INST_W-1:0] i_bus_rdata,
    output logic              o_bus_req,
    output logic [ADDR_W-1:0] o_bus_addr,
    input  logic              i_pc_jmp,
    input  logic [ADDR_W-1:0] i_pc_jmpaddr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_pc,
    output logic [INST_W-1:0] o_inst,
    output ifu_state_e        o_dbg_state
);

    localparam int CW = $clog2(FQ_DEPTH+1);
    localparam int FW = ADDR_W + INST_W;

    ifu_state_e        state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_pc_q;
    logic [INST_W-1:0] last_inst_q;

    logic [FW-1:0]     fq_dout;
    logic              fq_full;
    logic              fq_empty;
    logic [CW-1:0]     fq_count;

    logic              hs;
    logic              inflight;
    logic              issue;
    logic              byp;
    logic              byp_take;
    logic              fq_push;
    logic              fq_pop;
    logic [CW-1:0]     occ_next;
    logic              stay;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] addr_inc;

    assign hs       = req_q & i_bus_ack;
    assign inflight = (state_q != S_IDLE);
    assign issue    = ({1'b0, fq_count} + (CW+1)'(inflight)) < (CW+1)'(FQ_DEPTH);
    assign jmp_tgt  = i_pc_jmpaddr & ~ADDR_W'(3);
    assign addr_inc = addr_q + ADDR_W'(4);

`ifdef YSYX_210544_IFU_BYPASS_EN
    assign byp      = fq_empty & (state_q == S_REQ) & hs & ~i_pc_jmp;
    assign byp_take = byp & i_ready;
`else
    assign byp      = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign fq_pop   = ~fq_empty & i_ready & ~i_pc_jmp;
    assign fq_push  = (state_q == S_REQ) & hs & ~i_pc_jmp & ~byp_take & ~fq_full;
    // Occupancy after this edge decides whether the next request still has a slot.
    assign occ_next = fq_count + CW'(fq_push) - CW'(fq_pop);
    assign stay     = occ_next < CW'(FQ_DEPTH);

    ysyx_210544_fifo #(
        .WIDTH (FW),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (fq_push),
        .pop   (fq_pop),
        .flush (i_pc_jmp),
        .din   ({addr_q, i_bus_rdata}),
        .dout  (fq_dout),
        .full  (fq_full),
        .empty (fq_empty),
        .count (fq_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= PC_START;
            fetch_pc_q <= PC_START;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_pc_jmp) begin
                        fetch_pc_q <= jmp_tgt;
                    end else if (issue) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (i_pc_jmp) begin
                        fetch_pc_q <= jmp_tgt;
                        if (hs) begin
                            state_q <= S_IDLE;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= S_KILL;
                        end
                    end else if (hs) begin
                        fetch_pc_q <= addr_inc;
                        if (stay) begin
                            addr_q <= addr_inc;
                        end else begin
                            state_q <= S_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                S_KILL: begin
                    if (i_pc_jmp) fetch_pc_q <= jmp_tgt;
                    if (hs) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Remember whatever was last presented so an empty queue holds its outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc_q   <= '0;
            last_inst_q <= '0;
        end else if (o_valid) begin
            last_pc_q   <= o_pc;
            last_inst_q <= o_inst;
        end
    end

    assign o_bus_req   = req_q;
    assign o_bus_addr  = addr_q;
    assign o_valid     = ~fq_empty | byp;
    assign o_pc        = byp ? addr_q      : (fq_empty ? last_pc_q   : fq_dout[FW-1:INST_W]);
    assign o_inst      = byp ? i_bus_rdata : (fq_empty ? last_inst_q : fq_dout[INST_W-1:0]);
    assign o_dbg_state = state_q;

endmodule

// File: doc/ysyx_210544_ifu_fq.md
# ysyx_210544_ifu_fq

Next-generation fetch unit: prefetches sequential instructions over the single-request fetch bus into a parametrised fetch queue (FQ), and delivers `{pc, inst}` to decode through a valid/ready handshake. On a redirect from execute/writeback it flushes the queue and discards any in-flight bus response, then restarts at the jump target. It sits between the AXI fetch port adapter and the decode stage, and replaces the one-instruction-at-a-time fetch unit.

## Interface
- `ADDR_W`, 64: PC and bus address width.
- `INST_W`, 32: instruction width.
- `FQ_DEPTH`, 4: queue entries; power of two, ≥2.
- `PC_START`, `` `PC_START ``: fetch address after reset.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `i_bus_ack` in 1: bus response valid; it completes the request (handshake = `o_bus_req & i_bus_ack`).
- `i_bus_rdata` in INST_W: fetched instruction, valid with `i_bus_ack`.
- `o_bus_req` out 1: fetch request.
- `o_bus_addr` out ADDR_W: fetch address.
- `i_pc_jmp` in 1: redirect strobe, one cycle.
- `i_pc_jmpaddr` in ADDR_W: redirect target.
- `o_valid` out 1: the FQ head (or bypassed data) is valid.
- `i_ready` in 1: decode accepts the head.
- `o_pc` out ADDR_W: PC of the head.
- `o_inst` out INST_W: instruction of the head.

## Operation
- **FSM states:**
  - S_IDLE: no request outstanding.
  - S_REQ: request outstanding, its data will be kept.
  - S_KILL: request outstanding, its data will be discarded.
- **Issue condition:** `occ + inflight < FQ_DEPTH`.
  - `occ` is the FQ occupancy, width `$clog2(FQ_DEPTH+1)`.
  - `inflight` is 1 in S_REQ or S_KILL.
- **S_IDLE:**
  - If the issue condition holds, go to S_REQ, `o_bus_req<=1`, `o_bus_addr<=fetch_pc`.
- **S_REQ:**
  - `o_bus_req` and `o_bus_addr` are held stable until the handshake. A request is never withdrawn.
  - On the handshake, enqueue `{o_bus_addr, i_bus_rdata}` and set `fetch_pc<=o_bus_addr+4`.
  - After the handshake, stay in S_REQ with the next address if space remains, counting the entry just enqueued and any same-cycle pop. Otherwise go to S_IDLE with `o_bus_req<=0`.
- **Redirect (`i_pc_jmp`):** highest priority.
  - Flush the FQ (`occ<=0`, pointers reset).
  - Set `fetch_pc<={i_pc_jmpaddr[ADDR_W-1:2],2'b00}`.
  - From S_REQ without a same-cycle handshake, go to S_KILL.
  - From S_REQ with a same-cycle handshake, discard the data and go to S_IDLE.
  - In S_KILL, a further redirect updates `fetch_pc` only, with the latest target winning.
- **S_KILL:** on the handshake, drop the data, go to S_IDLE, and drop `o_bus_req`.
- **Pop:** `o_valid & i_ready`. A redirect in the same cycle overrides the pop, and the flush wins.
- **Address arithmetic:** `+4` modulo 2^ADDR_W. Address wrap-around is legal and silent.
- **Full FQ:** the issue condition is false, so no request is issued. Enqueue while full cannot occur.
- **Empty FQ:** `o_valid=0` (except when bypassing); `o_pc` and `o_inst` hold their last values.

## Timing
- **Reset values:**
  - `o_bus_req=0`.
  - `o_bus_addr=PC_START`, `fetch_pc=PC_START`.
  - `o_valid=0`, `o_pc=0`, `o_inst=0`.
  - FSM in S_IDLE.
- **First request:** `o_bus_req` rises on the first clock edge after `rst` deasserts.
- **Fetch latency:** handshake in cycle t gives `o_valid` in t+1 (no bypass).
- **Throughput:** one instruction per cycle when the bus acks every cycle and decode is always ready.
- **Redirect:** redirect in cycle t gives `o_valid=0` in t+1. The target request issues in t+1 from S_IDLE, or the cycle after the killed ack from S_KILL.
- **Outputs:** all registered except in the bypass path.

## Configuration
- **`YSYX_210544_IFU_BYPASS_EN` defined:**
  - When the FQ is empty, in S_REQ with no redirect, and a handshake occurs, `o_valid`/`o_pc`/`o_inst` are driven combinationally from the bus in the same cycle.
  - If `i_ready`, the entry is not enqueued.
  - Fetch-to-decode latency becomes 0 cycles.
- **Undefined:** all outputs come from FQ registers, with 1-cycle latency.

## Structure
- **`defines.v`:**
  - `` `PC_START ``.
  - State encodings `` `IFU_S_IDLE/REQ/KILL `` (2-bit).
  - `` `BUS_64 ``/`` `BUS_32 `` already exist.
- **Sub-module `ysyx_210544_fifo`:**
  - Generic synchronous FIFO with parameters `WIDTH` and `DEPTH`.
  - Ports: push, pop, flush, full, empty, count.
  - Instantiated with `WIDTH=ADDR_W+INST_W`.

## Test plan
- **Sequential fetch:**
  - Stimulus: reset release, ack every cycle with `rdata=addr[31:0]`, `i_ready=1`.
  - Required: `o_pc` sequence 0x80000000, …04, …08, with `o_valid` continuous.
- **Backpressure:**
  - Stimulus: `i_ready=0`, FQ_DEPTH=4.
  - Required: exactly 4 handshakes, then `o_bus_req` falls. Releasing `i_ready` drains PCs in order, then fetch resumes at +0x10.
- **Redirect with request outstanding:**
  - Stimulus: `i_pc_jmp` to 0x80001002 with ack delayed 3 cycles.
  - Required: the acked data is dropped and the next request address is 0x80001000.
- **Redirect and ack in the same cycle:**
  - Stimulus: `i_pc_jmp` and ack in the same cycle, plus a pop.
  - Required: the FQ is empty next cycle, no stale PC is delivered, and the next request is to the target.
- **Wrap-around:**
  - Stimulus: `PC_START=0xFFFFFFFF_FFFFFFFC`.
  - Required: the second fetch address is 0x0.
- **Reset mid-operation:**
  - Stimulus: assert `rst` while in S_KILL.
  - Required: all outputs take their reset values immediately (asynchronously), and fetch restarts at PC_START.
